// File: rtl/perip_bridge.sv
// perip_bridge: data-port decoder, DRAM sub-word store merger and
// MMIO block (switch synchronizer, LED register, prescaled timer).
module perip_bridge #(
  parameter int DRAM_AW   = 14,
  parameter int TIMER_DIV = 4,
  parameter int SW_W      = 24
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst_n,
  input  logic [31:0]        perip_addr,
  input  logic               perip_wen,
  input  logic [1:0]         perip_mask,
  input  logic [31:0]        perip_wdata,
  output logic [31:0]        perip_rdata,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic               dram_wen,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  input  logic [SW_W-1:0]    sw,
  output logic [SW_W-1:0]    led
);

  localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [PW-1:0] PRE_TOP = PW'(TIMER_DIV - 1);

  logic            is_mmio;
  logic [9:0]      woff;
  logic            sel_sw;
  logic            sel_cnt;
  logic            sel_ctrl;
  logic            sel_led;
  logic            mmio_wr;
  logic [SW_W-1:0] sw_meta;
  logic [SW_W-1:0] sw_sync;
  logic [31:0]     cnt;
  logic            en;
  logic [PW-1:0]   pre;
  logic [31:0]     merged;

  assign is_mmio  = perip_addr[31:12] == 20'hFFFFF;
  assign woff     = perip_addr[11:2];
  assign sel_sw   = is_mmio && woff == 10'h000;
  assign sel_cnt  = is_mmio && woff == 10'h008;
  assign sel_ctrl = is_mmio && woff == 10'h009;
  assign sel_led  = is_mmio && woff == 10'h018;
  assign mmio_wr  = is_mmio && perip_wen;

  always_comb begin
    perip_rdata = '0;
    unique case (1'b1)
      !is_mmio: perip_rdata = dram_rdata;
      sel_sw:   perip_rdata = 32'(sw_sync);
      sel_cnt:  perip_rdata = cnt;
      sel_ctrl: perip_rdata = {31'b0, en};
      sel_led:  perip_rdata = 32'(led);
      default:  perip_rdata = '0;
    endcase
  end

  // DRAM is word-write only: sub-word stores merge into the live word
  always_comb begin
    merged = dram_rdata;
    case (perip_mask)
      2'b00:   merged[{perip_addr[1:0], 3'b000} +: 8] = perip_wdata[7:0];
      2'b01:   merged[{perip_addr[1], 4'b0000} +: 16] = perip_wdata[15:0];
      default: merged = perip_wdata;
    endcase
  end

  assign dram_addr  = perip_addr[DRAM_AW+1:2];
  assign dram_wen   = perip_wen && !is_mmio;
  assign dram_wdata = merged;

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      sw_meta <= '0;
      sw_sync <= '0;
      led     <= '0;
      cnt     <= '0;
      en      <= 1'b0;
      pre     <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      if (mmio_wr && sel_led)
        led <= perip_wdata[SW_W-1:0];
      if (mmio_wr && sel_ctrl)
        en <= perip_wdata[0];
      // a count load beats a same-cycle increment
      if (mmio_wr && sel_cnt) begin
        cnt <= perip_wdata;
        pre <= '0;
      end else if (en) begin
        if (pre == PRE_TOP) begin
          pre <= '0;
          cnt <= cnt + 32'd1;
        end else begin
          pre <= pre + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_perip_bridge.sv
// tb_perip_bridge: random + directed stimulus, byte-level reference
// model, scoreboard queue drained by a negedge monitor.
module tb_perip_bridge;

  localparam int AW   = 14;
  localparam int DIV  = 4;
  localparam int SW_W = 24;

  localparam logic [31:0] A_SW   = 32'hFFFFF000;
  localparam logic [31:0] A_CNT  = 32'hFFFFF020;
  localparam logic [31:0] A_CTRL = 32'hFFFFF024;
  localparam logic [31:0] A_LED  = 32'hFFFFF060;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [31:0]     addr = '0;
  logic            wen = 1'b0;
  logic [1:0]      mask = 2'b10;
  logic [31:0]     wdata = '0;
  logic [31:0]     rdata;
  logic [AW-1:0]   daddr;
  logic            dwen;
  logic [31:0]     dwdata;
  logic [31:0]     drdata;
  logic [SW_W-1:0] sw = '0;
  logic [SW_W-1:0] led;
  logic            clear_mem = 1'b1;

  perip_bridge #(.DRAM_AW(AW), .TIMER_DIV(DIV), .SW_W(SW_W)) dut (
    .cpu_clk(clk), .cpu_rst_n(rst_n),
    .perip_addr(addr), .perip_wen(wen), .perip_mask(mask),
    .perip_wdata(wdata), .perip_rdata(rdata),
    .dram_addr(daddr), .dram_wen(dwen), .dram_wdata(dwdata),
    .dram_rdata(drdata), .sw(sw), .led(led)
  );

  always #5 clk = ~clk;

  // DRAM stub: async read, word write
  logic [31:0] dmem [0:(1<<AW)-1];
  assign drdata = dmem[daddr];
  always @(posedge clk) begin
    if (clear_mem) begin
      for (int i = 0; i < (1 << AW); i++) dmem[i] <= '0;
    end else if (dwen) begin
      dmem[daddr] <= dwdata;
    end
  end

  // reference model state
  logic [7:0]      refm [0:(1<<(AW+2))-1];
  logic [SW_W-1:0] m_led = '0;
  logic [31:0]     m_base = '0;
  int unsigned     m_ticks = 0;
  logic            m_en = 1'b0;
  logic [SW_W-1:0] h_old = '0;
  logic [SW_W-1:0] h_new = '0;

  typedef struct {
    int          id;
    logic [31:0] exp;
  } chk_t;
  chk_t sbq[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic string cname(int id);
    case (id)
      0: return "perip_rdata";
      1: return "dram_wen";
      2: return "dram_addr";
      3: return "dram_wdata";
      default: return "led";
    endcase
  endfunction

  function automatic logic [31:0] actual(int id);
    case (id)
      0: return rdata;
      1: return {31'b0, dwen};
      2: return 32'(daddr);
      3: return dwdata;
      default: return 32'(led);
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    chk_t c;
    logic [31:0] act;
    while (sbq.size() > 0) begin
      c = sbq.pop_front();
      act = actual(c.id);
      n_cmp++;
      if (act !== c.exp) begin
        n_bad++;
        $display("FAIL %s @%0t: got %h want %h", cname(c.id), $time, act, c.exp);
      end
    end
  end

  task automatic push(input int id, input logic [31:0] v);
    chk_t c;
    c.id = id;
    c.exp = v;
    sbq.push_back(c);
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    int b;
    b = int'(a[AW+1:0]) & ~3;
    return {refm[b+3], refm[b+2], refm[b+1], refm[b]};
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[31:12] != 20'hFFFFF) return rd_word(a);
    case (a[11:0] & 12'hFFC)
      12'h000: return 32'(h_old);
      12'h020: return m_base + m_ticks / DIV;
      12'h024: return {31'b0, m_en};
      12'h060: return 32'(m_led);
      default: return 32'h0;
    endcase
  endfunction

  // one bus cycle; entered and left at posedge+1
  task automatic step(input logic [31:0] a, input logic w,
                      input logic [1:0] m, input logic [31:0] d);
    logic       mm;
    logic [11:0] off;
    logic [7:0] by [4];
    int         wb;
    addr = a; wen = w; mask = m; wdata = d;
    mm  = a[31:12] == 20'hFFFFF;
    off = a[11:0] & 12'hFFC;
    push(0, model_read(a));
    push(1, 32'(w && !mm));
    push(4, 32'(m_led));
    if (!mm) begin
      wb = int'(a[AW+1:0]) & ~3;
      for (int i = 0; i < 4; i++) by[i] = refm[wb+i];
      case (m)
        2'b00: by[a[1:0]] = d[7:0];
        2'b01: begin
          by[{a[1], 1'b0}] = d[7:0];
          by[{a[1], 1'b1}] = d[15:8];
        end
        default: for (int i = 0; i < 4; i++) by[i] = d[8*i +: 8];
      endcase
      push(2, 32'(a[AW+1:2]));
      push(3, {by[3], by[2], by[1], by[0]});
      if (w) for (int i = 0; i < 4; i++) refm[wb+i] = by[i];
    end
    // effect of the coming edge
    if (w && mm && off == 12'h020) begin
      m_base = d;
      m_ticks = 0;
    end else if (m_en) begin
      m_ticks++;
    end
    if (w && mm && off == 12'h024) m_en = d[0];
    if (w && mm && off == 12'h060) m_led = d[SW_W-1:0];
    h_old = h_new;
    h_new = sw;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a);
    step(a, 1'b0, 2'b10, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(a, 1'b1, 2'b10, d);
  endtask

  task automatic reset_mid();
    addr = A_CNT; wen = 1'b0; mask = 2'b10;
    #1 rst_n = 1'b0;
    m_led = '0; m_base = '0; m_ticks = 0; m_en = 1'b0;
    h_old = '0; h_new = '0;
    push(0, 32'h0);
    push(4, 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    h_old = h_new;
    h_new = sw;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] offs [5];
    offs[0] = 32'h000; offs[1] = 32'h020; offs[2] = 32'h024;
    offs[3] = 32'h060; offs[4] = 32'h100;
    for (int i = 0; i < (1 << (AW + 2)); i++) refm[i] = '0;

    // power-on reset state
    @(posedge clk);
    #1;
    addr = A_CNT;
    push(0, 32'h0);
    push(4, 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    clear_mem = 1'b0;
    h_old = h_new;
    h_new = sw;
    @(posedge clk);
    #1;
    rd(A_CTRL);
    rd(A_LED);

    // word store then load
    wr(32'h0000_0104, 32'hDEADBEEF);
    rd(32'h0000_0104);

    // sub-word merges
    wr(32'h200, 32'h11223344);
    step(32'h202, 1'b1, 2'b00, 32'h000000AA);
    wr(32'h200, 32'h11223344);
    step(32'h203, 1'b1, 2'b01, 32'h0000BEEF);
    rd(32'h200);

    // MMIO isolation
    wr(A_LED, 32'h00ABCDEF);
    rd(A_LED);
    rd(32'hFFFFF100);

    // switch synchronizer
    sw = 24'h5A5A5A;
    rd(A_SW);
    rd(A_SW);
    rd(A_SW);

    // timer
    wr(A_CTRL, 32'h1);
    wr(A_CNT, 32'h0);
    repeat (12) rd(A_CNT);
    for (int k = 0; k < 8 && (m_ticks % DIV) != DIV - 1; k++) rd(A_CNT);
    wr(A_CNT, 32'hFFFFFFFF);
    repeat (5) rd(A_CNT);
    wr(A_CTRL, 32'h0);
    repeat (6) rd(A_CNT);

    // async reset mid-count
    wr(A_LED, 32'h00FFFFFF);
    wr(A_CTRL, 32'h1);
    repeat (5) rd(A_CNT);
    reset_mid();
    repeat (6) rd(A_CNT);
    rd(A_CTRL);
    rd(A_LED);
    wr(A_CTRL, 32'h1);
    repeat (6) rd(A_CNT);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) sw = SW_W'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        a = 32'hFFFFF000 | offs[$urandom_range(0, 4)] | 32'($urandom_range(0, 3));
        if (a[11:0] == 12'h024 || a[11:0] == 12'h025)
          step(a, 1'($urandom), 2'($urandom), 32'($urandom_range(0, 1)));
        else
          step(a, 1'($urandom), 2'($urandom), $urandom);
      end else begin
        a = $urandom & 32'h0003_01FF;
        step(a, 1'($urandom), 2'($urandom), $urandom);
      end
    end

    @(negedge clk);
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
